// File: rtl/screen_sequencer.sv
// screen_sequencer: frame-synchronous START/PLAY/WIN screen controller.
// Requests (start, game result) are held pending and applied only on the
// falling edge of vsync, so screen changes never tear mid-frame.
module screen_sequencer #(
   parameter int unsigned WIN_HOLD_FRAMES = 300
) (
   input  logic       clk_100MHz,
   input  logic       reset,
   input  logic       start,
   input  logic       ganadorX,
   input  logic       ganadorO,
   input  logic       tie,
   input  logic       vsync,
   output logic       ceSS,
   output logic       cePS,
   output logic       ceWS,
   output logic       game_reset,
   output logic [1:0] winner_code,
   output logic [1:0] screen_state
);

   localparam int unsigned CNT_W = 16;
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(WIN_HOLD_FRAMES - 1);

   typedef enum logic [1:0] {
      START   = 2'b00,
      PLAY    = 2'b01,
      WIN     = 2'b10,
      ILLEGAL = 2'b11
   } state_t;

   state_t             state, state_next;
   logic               pend, pend_next;
   logic [CNT_W-1:0]   frame_cnt, frame_cnt_next;
   logic [1:0]         code_next;
   logic               game_reset_next;
   logic               start_q, vsync_q;
   logic               start_rise, frame_tick, any_result;

   assign start_rise = start & ~start_q;
   assign frame_tick = vsync_q & ~vsync;
   assign any_result = ganadorX | ganadorO | tie;

   // State, pending request, frame counter, edge-detect history and registered outputs.
   always_ff @(posedge clk_100MHz) begin
      if (reset) begin
         state        <= START;
         pend         <= 1'b0;
         frame_cnt    <= '0;
         winner_code  <= 2'b00;
         game_reset   <= 1'b0;
         start_q      <= 1'b1;
         vsync_q      <= 1'b1;
         ceSS         <= 1'b1;
         cePS         <= 1'b0;
         ceWS         <= 1'b0;
         screen_state <= 2'b00;
      end else begin
         state        <= state_next;
         pend         <= pend_next;
         frame_cnt    <= frame_cnt_next;
         winner_code  <= code_next;
         game_reset   <= game_reset_next;
         start_q      <= start;
         vsync_q      <= vsync;
         ceSS         <= (state_next == START);
         cePS         <= (state_next == PLAY);
         ceWS         <= (state_next == WIN);
         screen_state <= state_next;
      end
   end

   // Next-state: latch requests, commit them on frame_tick only.
   always_comb begin
      state_next      = state;
      pend_next       = pend;
      frame_cnt_next  = frame_cnt;
      code_next       = winner_code;
      game_reset_next = 1'b0;
      case (state)
         START: begin
            if (frame_tick && pend) begin
               state_next      = PLAY;
               pend_next       = 1'b0;
               game_reset_next = 1'b1;
            end else if (start_rise) begin
               pend_next = 1'b1;
            end
         end
         PLAY: begin
            if (frame_tick && pend) begin
               state_next     = WIN;
               pend_next      = 1'b0;
               frame_cnt_next = '0;
            end else if (any_result && !pend) begin
               // First result seen wins; later changes are ignored.
               pend_next = 1'b1;
               code_next = ganadorX ? 2'b01 : (ganadorO ? 2'b10 : 2'b11);
            end
         end
         WIN: begin
            if (frame_tick) begin
               if (frame_cnt == HOLD_LAST) begin
                  state_next     = START;
                  code_next      = 2'b00;
                  frame_cnt_next = '0;
                  pend_next      = 1'b0;
               end else begin
                  frame_cnt_next = frame_cnt + CNT_W'(1);
               end
            end
         end
         default: begin
            state_next     = START;
            pend_next      = 1'b0;
            code_next      = 2'b00;
            frame_cnt_next = '0;
         end
      endcase
   end

endmodule

// File: tb/tb_screen_sequencer.sv
// Testbench for screen_sequencer: two instances (hold 3 and hold 1) share
// stimulus; a frame-level reference model checks every cycle, and scenario
// tasks check the specific behaviours.
module tb_screen_sequencer;

   localparam int FRAME = 16;

   logic clk_100MHz = 1'b0;
   logic reset = 1'b1, start = 1'b0, ganadorX = 1'b0, ganadorO = 1'b0, tie = 1'b0;
   logic vsync = 1'b1;

   logic       ceSS3, cePS3, ceWS3, game_reset3;
   logic [1:0] winner_code3, screen_state3;
   logic       ceSS1, cePS1, ceWS1, game_reset1;
   logic [1:0] winner_code1, screen_state1;

   int checks = 0;
   int errors = 0;
   int fcnt = 0;
   bit mon_en = 1'b1;

   screen_sequencer #(.WIN_HOLD_FRAMES(3)) u_dut3 (
      .clk_100MHz(clk_100MHz), .reset(reset), .start(start),
      .ganadorX(ganadorX), .ganadorO(ganadorO), .tie(tie), .vsync(vsync),
      .ceSS(ceSS3), .cePS(cePS3), .ceWS(ceWS3), .game_reset(game_reset3),
      .winner_code(winner_code3), .screen_state(screen_state3));

   screen_sequencer #(.WIN_HOLD_FRAMES(1)) u_dut1 (
      .clk_100MHz(clk_100MHz), .reset(reset), .start(start),
      .ganadorX(ganadorX), .ganadorO(ganadorO), .tie(tie), .vsync(vsync),
      .ceSS(ceSS1), .cePS(cePS1), .ceWS(ceWS1), .game_reset(game_reset1),
      .winner_code(winner_code1), .screen_state(screen_state1));

   logic [7:0] obs [2];
   assign obs[0] = {ceSS3, cePS3, ceWS3, game_reset3, winner_code3, screen_state3};
   assign obs[1] = {ceSS1, cePS1, ceWS1, game_reset1, winner_code1, screen_state1};

   always #5 clk_100MHz = ~clk_100MHz;

   // Frame generator: vsync low for the first two cycles of each FRAME-cycle frame.
   always @(negedge clk_100MHz) begin
      fcnt  = (fcnt == FRAME - 1) ? 0 : fcnt + 1;
      vsync = (fcnt >= 2);
   end

   // Reference model: screen mode, pending flag, result, frames left in WIN.
   int         m_mode [2];
   bit         m_pend [2];
   logic [1:0] m_code [2];
   int         m_left [2];
   bit         m_grst [2];
   bit         m_ps = 1'b1, m_pv = 1'b1;

   function automatic int hold_of(input int k);
      return (k == 0) ? 3 : 1;
   endfunction

   always @(posedge clk_100MHz) begin
      bit rise, tck, res;
      rise = start && !m_ps;
      tck  = m_pv && !vsync;
      res  = ganadorX || ganadorO || tie;
      for (int k = 0; k < 2; k++) begin
         m_grst[k] = 1'b0;
         if (reset) begin
            m_mode[k] = 0; m_pend[k] = 1'b0; m_code[k] = 2'b00; m_left[k] = 0;
         end else if (m_mode[k] == 0) begin
            if (tck && m_pend[k]) begin
               m_mode[k] = 1; m_pend[k] = 1'b0; m_grst[k] = 1'b1;
            end else if (rise) m_pend[k] = 1'b1;
         end else if (m_mode[k] == 1) begin
            if (tck && m_pend[k]) begin
               m_mode[k] = 2; m_pend[k] = 1'b0; m_left[k] = hold_of(k);
            end else if (res && !m_pend[k]) begin
               m_pend[k] = 1'b1;
               m_code[k] = ganadorX ? 2'b01 : (ganadorO ? 2'b10 : 2'b11);
            end
         end else if (tck) begin
            m_left[k] = m_left[k] - 1;
            if (m_left[k] == 0) begin
               m_mode[k] = 0; m_code[k] = 2'b00;
            end
         end
      end
      if (reset) begin m_ps = 1'b1; m_pv = 1'b1; end
      else begin m_ps = start; m_pv = vsync; end
   end

   // Every-cycle comparison of both instances against the model, plus one-hot enables.
   always @(posedge clk_100MHz) begin
      logic [7:0] ex;
      #1;
      if (mon_en) begin
         for (int k = 0; k < 2; k++) begin
            ex = {m_mode[k] == 0, m_mode[k] == 1, m_mode[k] == 2, m_grst[k], m_code[k], 2'(m_mode[k])};
            checks++;
            if (obs[k] !== ex) begin
               errors++;
               $display("FAIL model_hold%0d t=%0t: got %b required %b", hold_of(k), $time, obs[k], ex);
            end
            checks++;
            if (obs[k][7:5] !== 3'b100 && obs[k][7:5] !== 3'b010 && obs[k][7:5] !== 3'b001) begin
               errors++;
               $display("FAIL onehot_hold%0d t=%0t: got %b required one-hot", hold_of(k), $time, obs[k][7:5]);
            end
         end
      end
   end

   task automatic cyc(input int n = 1);
      repeat (n) begin @(posedge clk_100MHz); #1; end
   endtask

   task automatic wait_phase(input int ph);
      for (int i = 0; i <= FRAME && fcnt != ph; i++) cyc();
   endtask

   // Bounded wait for a hold-3 enable: sel 0 ceSS, 1 cePS, 2 ceWS.
   task automatic wait_en(input int sel, input int budget, output bit ok, output int n);
      ok = 1'b0;
      for (n = 1; n <= budget; n++) begin
         cyc();
         if ((sel == 0 && ceSS3 === 1'b1) || (sel == 1 && cePS3 === 1'b1) ||
             (sel == 2 && ceWS3 === 1'b1)) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      int grst_cnt, ss_bad;
      reset = 1'b1;
      cyc(2);
      checks++;
      if ({ceSS3, cePS3, ceWS3} !== 3'b100) begin
         errors++; $display("FAIL reset_enables: got %b required 100", {ceSS3, cePS3, ceWS3});
      end
      checks++;
      if ({game_reset3, winner_code3, screen_state3} !== 5'b0) begin
         errors++; $display("FAIL reset_values: got %b required 00000", {game_reset3, winner_code3, screen_state3});
      end
      reset = 1'b0;
      grst_cnt = 0; ss_bad = 0;
      repeat (3 * FRAME) begin
         cyc();
         if (game_reset3 === 1'b1) grst_cnt++;
         if (ceSS3 !== 1'b1 || screen_state3 !== 2'b00) ss_bad++;
      end
      checks++;
      if (grst_cnt != 0) begin errors++; $display("FAIL idle_game_reset: got %0d pulses required 0", grst_cnt); end
      checks++;
      if (ss_bad != 0) begin errors++; $display("FAIL idle_start_screen: got %0d bad cycles required 0", ss_bad); end
   endtask

   task automatic test_start_midframe();
      bit ok; int n;
      wait_phase(8);
      start = 1'b1; cyc(2); start = 1'b0;
      wait_en(1, 3 * FRAME, ok, n);
      checks++;
      if (!ok) begin errors++; $display("FAIL start_to_play: got timeout required cePS=1"); end
      checks++;
      if (fcnt != 0) begin errors++; $display("FAIL play_on_frame: got phase %0d required 0", fcnt); end
      checks++;
      if ({game_reset3, screen_state3} !== 3'b101) begin
         errors++; $display("FAIL play_entry: got %b required 101", {game_reset3, screen_state3});
      end
      cyc();
      checks++;
      if ({game_reset3, cePS3} !== 2'b01) begin
         errors++; $display("FAIL game_reset_width: got %b required 01", {game_reset3, cePS3});
      end
   endtask

   task automatic test_first_winner();
      bit ok; int n;
      wait_phase(2);
      cyc();
      ganadorO = 1'b1; cyc(10); ganadorX = 1'b1;
      wait_en(2, 3 * FRAME, ok, n);
      checks++;
      if (!ok || winner_code3 !== 2'b10) begin
         errors++; $display("FAIL first_winner: got ok=%0d code=%b required ok=1 code=10", ok, winner_code3);
      end
      ganadorO = 1'b0; ganadorX = 1'b0;
      checks++;
      if (ceWS1 !== 1'b1) begin errors++; $display("FAIL hold1_entry: got ceWS=%b required 1", ceWS1); end
      cyc();
      wait_phase(0);
      checks++;
      if ({ceSS1, winner_code1, ceWS3} !== 4'b1001) begin
         errors++; $display("FAIL hold1_one_frame: got %b required 1001", {ceSS1, winner_code1, ceWS3});
      end
      wait_en(0, 5 * FRAME, ok, n);
      checks++;
      if (!ok) begin errors++; $display("FAIL win_exit: got timeout required ceSS=1"); end
   endtask

   task automatic test_tie_hold();
      bit ok; int n, ticks;
      wait_phase(4);
      start = 1'b1; cyc(); start = 1'b0;
      wait_en(1, 3 * FRAME, ok, n);
      cyc(2);
      tie = 1'b1;
      wait_en(2, 3 * FRAME, ok, n);
      checks++;
      if (!ok || winner_code3 !== 2'b11) begin
         errors++; $display("FAIL tie_code: got ok=%0d code=%b required ok=1 code=11", ok, winner_code3);
      end
      tie = 1'b0;
      ticks = 0;
      for (int i = 0; i < 5 * FRAME; i++) begin
         cyc();
         if (fcnt == 0) ticks++;
         if (ceWS3 !== 1'b1) break;
         start = (fcnt == 6);
      end
      start = 1'b0;
      checks++;
      if (ticks != 3) begin errors++; $display("FAIL win_hold_frames: got %0d ticks required 3", ticks); end
      checks++;
      if ({ceSS3, cePS3, winner_code3} !== 4'b1000) begin
         errors++; $display("FAIL win_to_start: got %b required 1000", {ceSS3, cePS3, winner_code3});
      end
   endtask

   task automatic test_start_on_tick();
      bit ok; int n;
      start = 1'b0;
      cyc(2);
      wait_phase(FRAME - 1);
      start = 1'b1; cyc(); start = 1'b0;
      checks++;
      if ({ceSS3, screen_state3} !== 3'b100 || fcnt != 0) begin
         errors++; $display("FAIL coincident_defer: got %b phase %0d required 100 phase 0", {ceSS3, screen_state3}, fcnt);
      end
      wait_en(1, 2 * FRAME, ok, n);
      checks++;
      if (!ok || n != FRAME) begin
         errors++; $display("FAIL coincident_next_frame: got ok=%0d after %0d cycles required %0d", ok, n, FRAME);
      end
   endtask

   task automatic test_reset_in_win();
      bit ok; int n, ticks;
      ganadorX = 1'b1;
      wait_en(2, 3 * FRAME, ok, n);
      ganadorX = 1'b0;
      checks++;
      if (!ok || winner_code3 !== 2'b01) begin
         errors++; $display("FAIL x_winner: got ok=%0d code=%b required ok=1 code=01", ok, winner_code3);
      end
      ticks = 0;
      for (int i = 0; i < 3 * FRAME && ticks < 2; i++) begin
         cyc();
         if (fcnt == 0) ticks++;
      end
      cyc(3);
      checks++;
      if (ceWS3 !== 1'b1) begin errors++; $display("FAIL win_cnt2: got ceWS=%b required 1", ceWS3); end
      reset = 1'b1; cyc(); reset = 1'b0;
      checks++;
      if ({ceSS3, ceWS3, winner_code3, game_reset3} !== 5'b10000) begin
         errors++; $display("FAIL reset_in_win: got %b required 10000", {ceSS3, ceWS3, winner_code3, game_reset3});
      end
      cyc();
      checks++;
      if (game_reset3 !== 1'b0) begin errors++; $display("FAIL reset_no_pulse: got %b required 0", game_reset3); end
   endtask

   task automatic test_random();
      for (int i = 0; i < 4000; i++) begin
         cyc();
         if ($urandom_range(0, 29) == 0) start = ~start;
         if ($urandom_range(0, 59) == 0) ganadorX = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 59) == 0) ganadorO = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 59) == 0) tie = 1'($urandom_range(0, 1));
         reset = ($urandom_range(0, 999) == 0);
      end
      reset = 1'b0; start = 1'b0; ganadorX = 1'b0; ganadorO = 1'b0; tie = 1'b0;
      cyc(2);
   endtask

   initial begin
      test_reset();
      test_start_midframe();
      test_first_winner();
      test_tie_hold();
      test_start_on_tick();
      test_reset_in_win();
      test_random();
      mon_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/screen_sequencer.md
# screen_sequencer

Frame-synchronous screen controller for the TicTacToe VGA path. Generates the mutually exclusive screen enables (ceSS start screen, cePS play screen, ceWS winner screen) that the painter and screen decoder consume, so screen changes land only on a frame boundary. Also issues the one-cycle game-logic clear and latches the result shown on the winner screen. Sits between the game logic/buttons and the VGA painter.

## Interface

Parameters:
- WIN_HOLD_FRAMES, 300, frames the winner screen is held before returning to the start screen (valid range 1..65535).

Ports:
- clk_100MHz  input  1  system clock; one clock domain, all logic on its rising edge
- reset  input  1  synchronous, active-high; forces state START
- start  input  1  debounced start button, level; rising edge is the event
- ganadorX  input  1  X has won (level, held by game logic until cleared)
- ganadorO  input  1  O has won (level)
- tie  input  1  board full, no winner (level)
- vsync  input  1  VGA vertical sync from the sync unit, active-low
- ceSS  output  1  start-screen enable
- cePS  output  1  play-screen enable
- ceWS  output  1  winner-screen enable
- game_reset  output  1  one-cycle pulse clearing board, scores of the current round, turn
- winner_code  output  2  00 none, 01 X, 10 O, 11 tie; held while in WIN
- screen_state  output  2  00 START, 01 PLAY, 10 WIN (11 unused)

## Operation

- States: START (00), PLAY (01), WIN (10). Exactly one of ceSS/cePS/ceWS is 1 in every cycle, decoded from the state register: START→ceSS, PLAY→cePS, WIN→ceWS.
- Edge detects: start_q, vsync_q registered each cycle. start_rise = start & ~start_q. frame_tick = vsync_q & ~vsync (falling edge of vsync = start of sync pulse).
- Requests are latched into a single pending register and applied only on frame_tick.
- START: start_rise sets pend_play. On frame_tick with pend_play → PLAY, pend cleared, game_reset=1 for that one cycle.
- PLAY: any of ganadorX/ganadorO/tie sets pend_win and captures winner_code with priority X > O > tie (captured on the first cycle any is high; later changes ignored). On frame_tick with pend_win → WIN, frame_cnt cleared. start_rise ignored in PLAY.
- WIN: frame_cnt (16 bits) increments on each frame_tick. On frame_tick with frame_cnt == WIN_HOLD_FRAMES-1 → START, winner_code cleared to 00. start_rise ignored in WIN; no pending request survives a state change.
- Illegal state 11 → START on next cycle.
- Result inputs seen in START or WIN are ignored.

## Timing

- Reset (synchronous, cycle it is sampled high): state=START, ceSS=1, cePS=0, ceWS=0, game_reset=0, winner_code=00, screen_state=00, frame_cnt=0, pending cleared, start_q=1, vsync_q=1 (suppresses a spurious edge on the first cycle after reset).
- Outputs are registered. frame_tick evaluated in cycle N → new state and enables visible in cycle N+1; game_reset high in cycle N+1 only.
- Request latency: a request arriving in cycle N is applied at the first frame_tick in cycle ≥ N+1 (request and frame_tick in the same cycle waits for the next frame).
- Simultaneous start_rise and ganador in START: only start counts; ganador ignored.
- WIN_HOLD_FRAMES=1: WIN lasts exactly one frame (exits on first frame_tick after entry).
- Reset mid-WIN or mid-PLAY: immediate return to START, no game_reset pulse.

## Test plan

- Reset then idle 3 frames → ceSS=1, cePS=ceWS=0, screen_state=00, game_reset never pulses.
- Start pulse mid-frame → state stays START until next vsync falling edge; cycle after it cePS=1, screen_state=01, game_reset high exactly 1 cycle.
- In PLAY raise ganadorO, then ganadorX 10 cycles later → at next frame boundary ceWS=1, winner_code=10 (first captured, not overridden).
- WIN_HOLD_FRAMES=3, enter WIN with tie → ceWS=1 for exactly 3 frame_ticks, winner_code=11; start pulses during WIN ignored; then ceSS=1, winner_code=00.
- Start pulse coincident with frame_tick → transition deferred to the following frame_tick.
- Assert reset while in WIN with frame_cnt=2 → next cycle ceSS=1, winner_code=00, no game_reset; one-hot enables checked every cycle throughout.
